// File: rtl/sipo_shift_ctrl.sv
// Serial-capture controller with an embedded SIPO register and a valid/ready output handshake.
// A start request loads WIDTH serial bits, MSB first. The finished word is then held until the consumer accepts it.
module sipo_shift_ctrl #(
   parameter int WIDTH = 4,
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             din,
   input  logic             dout_ready,
   output logic             shift_en,
   output logic             busy,
   output logic [CW-1:0]    bit_cnt,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   output logic             overrun
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b001,
      ST_SHIFT = 3'b010,
      ST_HOLD  = 3'b100
   } state_t;

   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t state;

   // Sequencer, shift register and handshake flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         q       <= '0;
         bit_cnt <= '0;
         q_valid <= 1'b0;
         overrun <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state   <= ST_SHIFT;
                  bit_cnt <= '0;
               end
            end
            ST_SHIFT: begin
               q <= {q[WIDTH-2:0], din};
               if (bit_cnt == LAST_BIT) begin
                  state   <= ST_HOLD;
                  q_valid <= 1'b1;
                  bit_cnt <= '0;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            ST_HOLD: begin
               // A transfer with start high goes straight to SHIFT, with no idle cycle between words
               if (q_valid && dout_ready) begin
                  q_valid <= 1'b0;
                  state   <= start ? ST_SHIFT : ST_IDLE;
               end else if (start) begin
                  overrun <= 1'b1;
               end
            end
            default: begin
               state   <= ST_IDLE;
               q_valid <= 1'b0;
               bit_cnt <= '0;
            end
         endcase
      end
   end

   // Moore decode of the state register
   always_comb begin
      shift_en = 1'b0;
      busy     = 1'b0;
      if (state == ST_SHIFT) begin
         shift_en = 1'b1;
      end else begin
         shift_en = 1'b0;
      end
      if (state != ST_IDLE) begin
         busy = 1'b1;
      end else begin
         busy = 1'b0;
      end
   end

endmodule

// File: tb/tb_sipo_shift_ctrl.sv
// Directed bench for sipo_shift_ctrl (WIDTH=4) with hand-computed expected values.
module tb_sipo_shift_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       din;
   logic       dout_ready;
   logic       shift_en;
   logic       busy;
   logic [1:0] bit_cnt;
   logic [3:0] q;
   logic       q_valid;
   logic       overrun;

   int tests = 0;
   int fails = 0;

   sipo_shift_ctrl #(.WIDTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .din        (din),
      .dout_ready (dout_ready),
      .shift_en   (shift_en),
      .busy       (busy),
      .bit_cnt    (bit_cnt),
      .q          (q),
      .q_valid    (q_valid),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // start for one edge, then four serial bits (MSB first); ends in HOLD
   task automatic capture(input logic [3:0] w);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         din = w[i];
         step();
      end
   endtask

   initial begin
      logic [3:0] bits;
      rst = 1'b1; start = 1'b0; din = 1'b0; dout_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_valid", 32'(q_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_shift_en", 32'(shift_en), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);

      // 1: basic capture of 1011
      bits = 4'b1011;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t1_shift_en", 32'(shift_en), 32'h1);
         chk("t1_bit_cnt", 32'(bit_cnt), 32'(i));
         din = bits[3-i];
         step();
      end
      chk("t1_q", 32'(q), 32'hB);
      chk("t1_valid", 32'(q_valid), 32'h1);
      chk("t1_busy", 32'(busy), 32'h1);
      chk("t1_bit_cnt_hold", 32'(bit_cnt), 32'h0);
      chk("t1_shift_en_hold", 32'(shift_en), 32'h0);
      dout_ready = 1'b1;
      step();
      dout_ready = 1'b0;
      chk("t1_valid_after", 32'(q_valid), 32'h0);
      chk("t1_busy_after", 32'(busy), 32'h0);
      chk("t1_q_kept", 32'(q), 32'hB);

      // 2: backpressure while din toggles
      capture(4'b0110);
      for (int i = 0; i < 6; i++) begin
         din = ~din;
         step();
         chk("t2_q_frozen", 32'(q), 32'h6);
         chk("t2_valid_held", 32'(q_valid), 32'h1);
      end
      dout_ready = 1'b1;
      step();
      dout_ready = 1'b0;
      chk("t2_valid_drop", 32'(q_valid), 32'h0);

      // 3: back-to-back words 1100 then 0101
      start = 1'b1;
      dout_ready = 1'b1;
      step();
      bits = 4'b1100;
      for (int i = 3; i >= 0; i--) begin
         din = bits[i];
         step();
      end
      chk("t3_q1", 32'(q), 32'hC);
      chk("t3_valid1", 32'(q_valid), 32'h1);
      chk("t3_shift_en_hold", 32'(shift_en), 32'h0);
      din = 1'b1;
      step();
      chk("t3_no_bubble", 32'(shift_en), 32'h1);
      chk("t3_valid_gap", 32'(q_valid), 32'h0);
      chk("t3_busy_gap", 32'(busy), 32'h1);
      bits = 4'b0101;
      for (int i = 3; i >= 0; i--) begin
         din = bits[i];
         step();
      end
      chk("t3_q2", 32'(q), 32'h5);
      chk("t3_valid2", 32'(q_valid), 32'h1);
      chk("t3_overrun", 32'(overrun), 32'h0);
      start = 1'b0;
      step();
      dout_ready = 1'b0;
      chk("t3_idle", 32'(busy), 32'h0);

      // 4: overrun on start in HOLD without ready
      capture(4'b1001);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("t4_overrun", 32'(overrun), 32'h1);
      chk("t4_hold_valid", 32'(q_valid), 32'h1);
      chk("t4_hold_shift_en", 32'(shift_en), 32'h0);
      chk("t4_hold_q", 32'(q), 32'h9);
      dout_ready = 1'b1;
      step();
      dout_ready = 1'b0;
      chk("t4_idle_busy", 32'(busy), 32'h0);
      step();
      step();
      chk("t4_overrun_sticky", 32'(overrun), 32'h1);

      // 5: asynchronous reset mid-shift
      start = 1'b1;
      step();
      start = 1'b0;
      din = 1'b1;
      step();
      din = 1'b0;
      step();
      chk("t5_mid_cnt", 32'(bit_cnt), 32'h2);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_async_q", 32'(q), 32'h0);
      chk("t5_async_busy", 32'(busy), 32'h0);
      chk("t5_async_shift_en", 32'(shift_en), 32'h0);
      chk("t5_async_cnt", 32'(bit_cnt), 32'h0);
      chk("t5_async_overrun", 32'(overrun), 32'h0);
      chk("t5_async_valid", 32'(q_valid), 32'h0);
      #1;
      rst = 1'b0;
      step();
      capture(4'b1101);
      chk("t5_recap_q", 32'(q), 32'hD);
      chk("t5_recap_valid", 32'(q_valid), 32'h1);
      dout_ready = 1'b1;
      step();
      dout_ready = 1'b0;

      // 6: start pulsed during SHIFT is ignored
      bits = 4'b0111;
      start = 1'b1;
      step();
      start = 1'b0;
      din = bits[3];
      step();
      start = 1'b1;
      din = bits[2];
      step();
      start = 1'b0;
      din = bits[1];
      step();
      chk("t6_not_early", 32'(q_valid), 32'h0);
      din = bits[0];
      step();
      chk("t6_q", 32'(q), 32'h7);
      chk("t6_valid", 32'(q_valid), 32'h1);
      chk("t6_overrun", 32'(overrun), 32'h0);
      dout_ready = 1'b1;
      step();
      dout_ready = 1'b0;
      chk("t6_idle", 32'(busy), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
